control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter CMD_W, default 16: width of command_code.
REQ-002 Parameter ALU_W, default 8: width of alu_control_command.
REQ-003 Parameter MUL_CYCLES, default 3, legal range 1..255: ALU cycles consumed by MUL (opcode 3).
REQ-004 Parameter COUNT_W, default 16: width of retired_count.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port cmd_valid, input, 1: command_code is presented.
REQ-008 Port cmd_ready, output, 1: block accepts a command this cycle.
REQ-009 Port command_code, input, CMD_W: opcode.
REQ-010 Port alu_control_command, output, ALU_W: ALU operation select.
REQ-011 Port alu_start, output, 1: one-cycle ALU launch strobe.
REQ-012 Port regwrite_control, output, 1: one-cycle register-file write enable.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port illegal_op, output, 1: one-cycle pulse on acceptance of an illegal code.
REQ-015 Port illegal_trap, output, 1: sticky trap flag (see Configuration).
REQ-016 Port retired_count, output, COUNT_W: number of completed write-backs.

Function
REQ-017 States SHALL be IDLE, EXEC, WAIT, WB; cmd_ready = 1 only in IDLE (and trap clear).
REQ-018 Acceptance: cmd_valid & cmd_ready at a rising edge (cycle A); command_code SHALL be latched at that edge.
REQ-019 Legal codes: value 1..16 with all bits above bit 4 zero; alu_control_command = code[ALU_W-1:0] for legal ops.
REQ-020 Legal accept: IDLE -> EXEC; alu_start = 1 during cycle A+1 only.
REQ-021 Op latency L = MUL_CYCLES for opcode 3, else 1; EXEC lasts 1 cycle, WAIT lasts L-1 cycles (skipped when L = 1), countdown counter sized for 255.
REQ-022 WB occupies cycle A+1+L with regwrite_control = 1; state returns to IDLE at A+2+L.
REQ-023 alu_control_command SHALL hold the latched op from EXEC through WB and be 0 in IDLE.
REQ-024 Illegal accept (0, 17+, or nonzero high bits): state stays IDLE, illegal_op = 1 in cycle A+1, no alu_start, no regwrite, counter unchanged.
REQ-025 retired_count increments by 1 at the end of each WB cycle, wrapping from 2^COUNT_W-1 to 0.
REQ-026 cmd_valid while busy SHALL be ignored (no queueing); upstream holds it until cmd_ready.
REQ-027 Back-to-back throughput: one legal op per L+2 cycles.

Reset
REQ-028 reset at any edge, including mid-EXEC/WAIT/WB, SHALL force IDLE, abort the op with no further regwrite/alu_start.
REQ-029 Reset values: cmd_ready = 1, alu_control_command = 0, alu_start = 0, regwrite_control = 0, busy = 0, illegal_op = 0, illegal_trap = 0, retired_count = 0.
REQ-030 reset SHALL dominate cmd_valid in the same cycle.

Configuration
REQ-031 Macro CONTROL_ILLEGAL_TRAP_EN defined: illegal accept also sets illegal_trap = 1 from cycle A+1; while set, cmd_ready = 0; cleared only by reset.
REQ-032 Macro undefined: illegal_trap tied 0; block remains ready after an illegal op.

Verification
REQ-033 Reset, then code 1 at cycle 0 -> alu_start cycle 1, alu_control_command 0x01 cycles 1-2, regwrite cycle 2, cmd_ready cycle 3, retired_count 1.
REQ-034 MUL_CYCLES=3, code 3 at cycle 0 -> WAIT cycles 2-3, regwrite cycle 4 only, ready cycle 5.
REQ-035 Code 0x0011 then code 0x0101 -> illegal_op pulse each, no regwrite, count unchanged; with trap macro, cmd_ready stays 0 after first until reset.
REQ-036 Reset asserted in WAIT of a MUL -> IDLE next cycle, no regwrite ever issued, retired_count 0.
REQ-037 COUNT_W=4, 17 back-to-back ADDs with cmd_valid held high -> retired_count wraps to 1; cmd_valid during busy causes no extra accepts.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: command sequencer driving ALU launch, latency wait and register write-back.
// Optional sticky illegal-op trap enabled by defining CONTROL_ILLEGAL_TRAP_EN.
module control_fsm #(
    parameter int CMD_W      = 16,
    parameter int ALU_W      = 8,
    parameter int MUL_CYCLES = 3,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_W-1:0]   command_code,
    output logic [ALU_W-1:0]   alu_control_command,
    output logic               alu_start,
    output logic               regwrite_control,
    output logic               busy,
    output logic               illegal_op,
    output logic               illegal_trap,
    output logic [COUNT_W-1:0] retired_count
);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, WB} state_t;
    state_t             state_q;
    logic [7:0]         cnt_q;
    logic [ALU_W-1:0]   alu_cmd_q;
    logic               ready_q, start_q, wr_q, ill_q, trap_q;
    logic [COUNT_W-1:0] count_q;
    logic               legal;
    assign legal = command_code != '0 && command_code <= CMD_W'(16);
    // cnt_q holds the number of WAIT cycles still to run after EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_cmd_q <= '0;
            ready_q   <= 1'b1;
            start_q   <= 1'b0;
            wr_q      <= 1'b0;
            ill_q     <= 1'b0;
            trap_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid && ready_q) begin
                    if (legal) begin
                        state_q   <= EXEC;
                        alu_cmd_q <= ALU_W'(command_code);
                        cnt_q     <= command_code == CMD_W'(3) ? 8'(MUL_CYCLES - 1) : 8'd0;
                        start_q   <= 1'b1;
                        ready_q   <= 1'b0;
                    end else begin
                        ill_q <= 1'b1;
                        if (TRAP_EN) begin
                            trap_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    state_q <= cnt_q == 8'd0 ? WB : WAIT;
                    wr_q    <= cnt_q == 8'd0;
                end
                WAIT: begin
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= cnt_q == 8'd1 ? WB : WAIT;
                    wr_q    <= cnt_q == 8'd1;
                end
                WB: begin
                    state_q   <= IDLE;
                    alu_cmd_q <= '0;
                    ready_q   <= 1'b1;
                    count_q   <= count_q + 1'b1;
                end
            endcase
        end
    end
    assign cmd_ready           = ready_q;
    assign alu_control_command = alu_cmd_q;
    assign alu_start           = start_q;
    assign regwrite_control    = wr_q;
    assign busy                = state_q != IDLE;
    assign illegal_op          = ill_q;
    assign illegal_trap        = trap_q;
    assign retired_count       = count_q;
endmodule
